// File: rtl/bus_ctrl_if.sv
// CPU-side and memory-side signal bundle for bus_ctrl.
// The controller uses the slave modport. The master modport is the CPU/memory side.
interface bus_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_n;
  logic              mem_wr_n;
  logic              buf_en;
  logic [DATA_W-1:0] buf_wdata;
  logic [DATA_W-1:0] buf_rdata;
  logic              mem_rdy;

  modport slave (
    input  req, we, addr, wdata, buf_rdata, mem_rdy,
    output busy, ack, err, rdata, mem_addr, mem_rd_n, mem_wr_n, buf_en, buf_wdata
  );

  modport master (
    output req, we, addr, wdata, buf_rdata, mem_rdy,
    input  busy, ack, err, rdata, mem_addr, mem_rd_n, mem_wr_n, buf_en, buf_wdata
  );
endinterface

// File: rtl/bus_ctrl.sv
// Four-state external memory bus controller (IDLE/SETUP/ACCESS/DONE).
// Optional access timeout enabled with macro BUS_CTRL_TIMEOUT_EN.
module bus_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  bus_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic              r_we;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_bufWdata;
  logic [DATA_W-1:0] r_rdata;
  logic              w_capture;
  logic              w_rdN;
  logic              w_wrN;
  logic              w_bufEn;
  logic              w_ack;
  logic              w_busy;
  logic              w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_rdN       = 1'b1;
    w_wrN       = 1'b1;
    w_bufEn     = 1'b0;
    w_ack       = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.req) begin
          w_capture   = 1'b1;
          w_nextState = SETUP;
        end
      end
      SETUP: begin
        w_bufEn     = r_we;
        w_nextState = ACCESS;
      end
      ACCESS: begin
        w_bufEn = r_we;
        w_rdN   = r_we;
        w_wrN   = ~r_we;
        if (bus.mem_rdy || w_timeout) w_nextState = DONE;
      end
      DONE: begin
        w_ack       = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // rdata only moves on a completed read; writes and aborts leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_memAddr  <= '0;
      r_bufWdata <= '0;
      r_rdata    <= '0;
    end else begin
      if (w_capture) begin
        r_we       <= bus.we;
        r_memAddr  <= bus.addr;
        r_bufWdata <= bus.wdata;
      end
      if (r_state == ACCESS && bus.mem_rdy && !r_we) r_rdata <= bus.buf_rdata;
    end
  end

`ifdef BUS_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_abort;

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_abort   = (r_state == ACCESS) && !bus.mem_rdy && w_timeout;

  // Counter is zero in the first ACCESS cycle; err is high only in the DONE after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == ACCESS) ? r_cnt + CNT_W'(1) : '0;
      r_err <= w_abort;
    end
  end

  assign bus.err = r_err;
`else
  logic w_unused;

  assign w_timeout = 1'b0;
  assign w_unused  = ^TIMEOUT;
  assign bus.err   = 1'b0;
`endif

  assign bus.busy      = w_busy;
  assign bus.ack       = w_ack;
  assign bus.mem_rd_n  = w_rdN;
  assign bus.mem_wr_n  = w_wrN;
  assign bus.buf_en    = w_bufEn;
  assign bus.mem_addr  = r_memAddr;
  assign bus.buf_wdata = r_bufWdata;
  assign bus.rdata     = r_rdata;

endmodule

// File: tb/tb_bus_ctrl.sv
// Self-checking bench for bus_ctrl: directed scenarios plus random transfers against a per-transfer model.
module tb_bus_ctrl;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] modelRdata = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] rdIn, input logic rdy);
    bus.req       = req;
    bus.we        = we;
    bus.addr      = addr;
    bus.wdata     = wdata;
    bus.buf_rdata = rdIn;
    bus.mem_rdy   = rdy;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One full transfer: SETUP, then (waits+1) ACCESS cycles (TMO if aborting), then DONE, then IDLE.
  task automatic runTransfer(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input logic [DW-1:0] rdIn, input int waits, input bit abort);
    int accessCycles;
    accessCycles = abort ? TMO : waits + 1;
    checkOutput("idleBusyBefore", bus.busy, 0);
    applyStimulus(1'b1, we, addr, wdata, rdIn, 1'b0);
    nextCycle();
    applyStimulus(1'b0, ~we, ~addr, ~wdata, rdIn, 1'b0);
    checkOutput("setupBusy", bus.busy, 1);
    checkOutput("setupRdN", bus.mem_rd_n, 1);
    checkOutput("setupWrN", bus.mem_wr_n, 1);
    checkOutput("setupBufEn", bus.buf_en, {31'b0, we});
    checkOutput("setupMemAddr", bus.mem_addr, {24'b0, addr});
    checkOutput("setupBufWdata", bus.buf_wdata, {24'b0, wdata});
    checkOutput("setupAck", bus.ack, 0);
    for (int i = 0; i < accessCycles; i++) begin
      nextCycle();
      bus.mem_rdy = !abort && (i == waits);
      checkOutput("accessRdN", bus.mem_rd_n, {31'b0, we});
      checkOutput("accessWrN", bus.mem_wr_n, {31'b0, ~we});
      checkOutput("accessBufEn", bus.buf_en, {31'b0, we});
      checkOutput("accessStrobes", {31'b0, bus.mem_rd_n | bus.mem_wr_n}, 1);
      checkOutput("accessAck", bus.ack, 0);
      checkOutput("accessMemAddr", bus.mem_addr, {24'b0, addr});
    end
    nextCycle();
    bus.mem_rdy = 1'b0;
    if (!we && !abort) modelRdata = rdIn;
    checkOutput("doneAck", bus.ack, 1);
    checkOutput("doneErr", bus.err, {31'b0, abort});
    checkOutput("doneRdN", bus.mem_rd_n, 1);
    checkOutput("doneWrN", bus.mem_wr_n, 1);
    checkOutput("doneBufEn", bus.buf_en, 0);
    checkOutput("doneBusy", bus.busy, 1);
    checkOutput("doneRdata", bus.rdata, {24'b0, modelRdata});
    nextCycle();
    checkOutput("idleBusy", bus.busy, 0);
    checkOutput("idleAck", bus.ack, 0);
    checkOutput("idleErr", bus.err, 0);
    checkOutput("idleRdata", bus.rdata, {24'b0, modelRdata});
    checkOutput("idleMemAddrHold", bus.mem_addr, {24'b0, addr});
    checkOutput("idleBufWdataHold", bus.buf_wdata, {24'b0, wdata});
  endtask

  initial begin
    logic [AW-1:0] acceptAddr;
    int ackCount;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0);
    #1;
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstRdN", bus.mem_rd_n, 1);
    checkOutput("rstWrN", bus.mem_wr_n, 1);
    checkOutput("rstBufEn", bus.buf_en, 0);
    checkOutput("rstAck", bus.ack, 0);
    checkOutput("rstErr", bus.err, 0);
    checkOutput("rstRdata", bus.rdata, 0);
    checkOutput("rstMemAddr", bus.mem_addr, 0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;

    runTransfer(1'b1, 8'h3C, 8'h6D, 8'h00, 0, 1'b0);
    runTransfer(1'b0, 8'h10, 8'h00, 8'hA5, 3, 1'b0);
    runTransfer(1'b1, 8'h20, 8'hFF, 8'h00, 0, 1'b0);
    runTransfer(1'b0, 8'h20, 8'h00, 8'h00, 1, 1'b0);

    for (int n = 0; n < 20; n++) begin
      runTransfer(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                  int'($urandom_range(0, 3)), 1'b0);
    end

    // req held high with a ready memory: one transfer every four cycles, new address each cycle.
    acceptAddr = 8'h41;
    applyStimulus(1'b1, 1'b1, acceptAddr, 8'h99, 8'h00, 1'b1);
    ackCount = 0;
    for (int k = 0; k < 40; k++) begin
      nextCycle();
      if (bus.ack) ackCount++;
      checkOutput("contAck", bus.ack, {31'b0, (k % 4) == 2});
      checkOutput("contBusy", bus.busy, {31'b0, (k % 4) != 3});
      if (k % 4 == 0) checkOutput("contMemAddr", bus.mem_addr, {24'b0, acceptAddr});
      bus.addr = AW'($urandom);
      if (k % 4 == 3) acceptAddr = bus.addr;
    end
    bus.req = 1'b0;
    bus.mem_rdy = 1'b0;
    checkOutput("contAckCount", ackCount, 10);
    checkOutput("contRdata", bus.rdata, {24'b0, modelRdata});

    // Reset pulsed during the ACCESS phase of a write.
    runTransfer(1'b0, 8'h11, 8'h00, 8'hA5, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h5A, 8'hC3, 8'h00, 1'b0);
    nextCycle();
    bus.req = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("preRstWrN", bus.mem_wr_n, 0);
    rst_n = 1'b0;
    #1;
    modelRdata = '0;
    checkOutput("midRstRdN", bus.mem_rd_n, 1);
    checkOutput("midRstWrN", bus.mem_wr_n, 1);
    checkOutput("midRstBufEn", bus.buf_en, 0);
    checkOutput("midRstBusy", bus.busy, 0);
    checkOutput("midRstRdata", bus.rdata, 0);
    checkOutput("midRstBufWdata", bus.buf_wdata, 0);
    #2;
    rst_n = 1'b1;
    runTransfer(1'b0, 8'h12, 8'h00, 8'h3E, 0, 1'b0);

`ifdef BUS_CTRL_TIMEOUT_EN
    runTransfer(1'b0, 8'h22, 8'h00, 8'h77, 0, 1'b1);
    runTransfer(1'b0, 8'h23, 8'h00, 8'h77, TMO - 1, 1'b0);
`else
    runTransfer(1'b0, 8'h24, 8'h00, 8'h77, 20, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_ctrl.md
BUS_CTRL -- requirements
Module: bus_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, width of the address path.
REQ-002 Parameter DATA_W, default 8, width of the data path.
REQ-003 Parameter TIMEOUT, default 15, maximum ACCESS cycles before an abort (used only with BUS_CTRL_TIMEOUT_EN).
REQ-004 One clock and an asynchronous active-low reset; all state changes on the rising edge of clk.
REQ-005 clk  in  1  system clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req  in  1  CPU transfer request, sampled only in IDLE.
REQ-008 we  in  1  1=write, 0=read; sampled with req.
REQ-009 addr  in  ADDR_W  transfer address; sampled with req.
REQ-010 wdata  in  DATA_W  write data; sampled with req.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 ack  out  1  one-cycle completion pulse.
REQ-013 err  out  1  one-cycle abort flag, coincident with ack.
REQ-014 rdata  out  DATA_W  last captured read data.
REQ-015 mem_addr  out  ADDR_W  external address, held for the whole transfer.
REQ-016 mem_rd_n  out  1  active-low read strobe.
REQ-017 mem_wr_n  out  1  active-low write strobe.
REQ-018 buf_en  out  1  bidirectional-buffer drive enable; 1 drives buf_wdata onto the bus.
REQ-019 buf_wdata  out  DATA_W  data presented to the buffer's drive side.
REQ-020 buf_rdata  in  DATA_W  data received from the buffer's bus side.
REQ-021 mem_rdy  in  1  memory ready, sampled in ACCESS.

Function
REQ-022 The FSM SHALL have exactly four states: IDLE, SETUP, ACCESS and DONE.
REQ-023 IDLE -> SETUP on req=1: capture addr, we and wdata into mem_addr, an internal we register and buf_wdata.
REQ-024 SETUP lasts one cycle.
  - Strobes stay high (inactive).
  - buf_en = captured we.
  - Next state is ACCESS.
REQ-025 ACCESS behaviour:
  - mem_rd_n=0 for a read; mem_wr_n=0 for a write.
  - buf_en stays at the captured we.
  - The state is held while mem_rdy=0.
REQ-026 ACCESS with mem_rdy=1 -> DONE; for a read, buf_rdata is registered into rdata on that same edge.
REQ-027 DONE lasts one cycle.
  - Both strobes high; buf_en=0.
  - ack=1.
  - Next state is IDLE.
REQ-028 Zero-wait latency: req accepted at edge N gives ack high during cycle N+3; minimum 4 cycles between accepted requests.
REQ-029 req while busy=1 SHALL be ignored, not queued.
REQ-030 mem_rd_n and mem_wr_n SHALL never both be low; buf_en SHALL never be 1 during a read.
REQ-031 rdata SHALL change only on a successful read completion and SHALL hold across writes and aborts.
REQ-032 mem_addr and buf_wdata SHALL hold their last values in IDLE.

Reset
REQ-033 rst_n=0 SHALL immediately force the following, including mid-transfer:
  - state IDLE;
  - mem_rd_n=1, mem_wr_n=1;
  - buf_en=0, ack=0, err=0, busy=0;
  - rdata, mem_addr and buf_wdata all 0;
  - timeout counter 0.
REQ-034 After rst_n deasserts, the first req SHALL be accepted on the first clock edge.

Configuration
REQ-035 Macro BUS_CTRL_TIMEOUT_EN defined:
  - An ACCESS-cycle counter starts at 0 on entry to ACCESS.
  - If TIMEOUT cycles elapse with mem_rdy=0, the FSM goes to DONE with ack=1, err=1 and rdata unchanged.
  - mem_rdy=1 on the final allowed cycle completes normally with err=0.
REQ-036 Macro BUS_CTRL_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; err is tied to 0.

Verification
REQ-037 Reset, then write addr=0x3C, wdata=0x6D, mem_rdy=1 -> mem_wr_n low for one cycle, buf_en=1 in SETUP and ACCESS, buf_wdata=0x6D, ack at cycle N+3, err=0.
REQ-038 Read addr=0x10 with buf_rdata=0xA5 and mem_rdy low for 3 ACCESS cycles -> mem_rd_n low for 4 cycles, buf_en=0 throughout, rdata=0xA5 with ack.
REQ-039 req held high continuously -> exactly one transfer per 4 cycles (zero wait), no req accepted while busy.
REQ-040 rst_n pulsed low during ACCESS of a write -> strobes and buf_en go inactive immediately, rdata=0x00, busy=0.
REQ-041 With BUS_CTRL_TIMEOUT_EN and mem_rdy=0 forever -> ack=1 and err=1 after 15 ACCESS cycles, rdata unchanged; repeat with mem_rdy=1 on cycle 15 -> err=0.
REQ-042 Write 0xFF followed by read returning 0x00 -> rdata=0x00, buf_en=0 during the read, strobes never both low.
